// File: rtl/pattern_detector_pkg.sv
// pattern_detector_pkg: shared state encoding, default sizes and config helpers for pattern_detector
package pattern_detector_pkg;

    typedef enum logic [1:0] {IDLE, FILL, ARMED} state_t;

    localparam int DEF_MAX_LEN = 8;
    localparam int DEF_CNT_W   = 8;

    function automatic int len_clamp(input int len, input int max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/pattern_detector_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear; clear and increment together yield 1
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] base;

    assign base = clr ? '0 : q;

    always_ff @(posedge clk) begin
        if (!reset)
            q <= '0;
        else
            q <= base + W'(inc && !(&base));
    end

endmodule

// File: rtl/pattern_detector.sv
// pattern_detector: programmable serial pattern matcher with overlap control and saturating hit count
module pattern_detector
    import pattern_detector_pkg::*;
#(
    parameter  int MAX_LEN = DEF_MAX_LEN,
    parameter  int CNT_W   = DEF_CNT_W,
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] pat,
    input  logic [LEN_W-1:0]   pat_len,
    input  logic               overlap,
    input  logic               en,
    input  logic               data_in,
    input  logic               clr_cnt,
    output logic               match,
    output logic               armed,
    output logic [CNT_W-1:0]   match_cnt
);

    state_t             state, state_nx;
    logic [MAX_LEN-2:0] hist;
    logic [MAX_LEN-1:0] cfg_pat, nh, mask;
    logic [LEN_W-1:0]   fill, fill_inc, cfg_len, len_in;
    logic [LEN_W:0]     fill_p1;
    logic               cfg_ovl, full, hit, restart;

    assign len_in   = LEN_W'(len_clamp(int'(pat_len), MAX_LEN));
    assign nh       = {hist, data_in};
    assign fill_p1  = {1'b0, fill} + 1'b1;
    assign full     = fill_p1 >= {1'b0, cfg_len};
    assign fill_inc = (fill == LEN_W'(MAX_LEN)) ? fill : fill + 1'b1;

    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++)
            mask[i] = i < int'(cfg_len);
    end

    assign hit     = en && !cfg_load && state != IDLE && full && ((nh ^ cfg_pat) & mask) == '0;
    // a non-overlapping hit forgets the history so the next match needs cfg_len fresh bits
    assign restart = hit && !cfg_ovl;

    always_ff @(posedge clk) begin
        if (!reset) begin
            hist    <= '0;
            fill    <= '0;
            cfg_pat <= '0;
            cfg_len <= '0;
            cfg_ovl <= 1'b0;
            match   <= 1'b0;
        end else begin
            match <= hit;
            if (cfg_load) begin
                cfg_pat <= pat;
                cfg_len <= len_in;
                cfg_ovl <= overlap;
                hist    <= '0;
                fill    <= '0;
            end else if (en) begin
                hist <= restart ? '0 : nh[MAX_LEN-2:0];
                fill <= restart ? '0 : fill_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (cfg_load)
            state_nx = (len_in != '0) ? FILL : IDLE;
        else if (en && state != IDLE)
            state_nx = hit ? ((cfg_ovl || cfg_len == LEN_W'(1)) ? ARMED : FILL)
                           : ((state == FILL && full) ? ARMED : FILL);
    end

    always_comb armed = (state == ARMED);

    sat_counter #(.W(CNT_W)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clr_cnt),
        .inc   (hit),
        .q     (match_cnt)
    );

endmodule

// File: doc/pattern_detector.md
Name: pattern_detector

Overview:
Parametrised serial bit-pattern detector, the successor to the fixed "four consecutive ones" detector. It matches a programmable pattern of 1..MAX_LEN bits against a gated serial stream, in overlapping or non-overlapping mode. It emits a one-cycle match pulse and keeps a saturating match count. It sits on the serial receive path, ahead of message framing logic.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (>=2)
CNT_W, 8, match counter width (>=2)
LEN_W, $clog2(MAX_LEN+1), width of pat_len (derived, not overridden)

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-low reset (clears state when sampled low at clk rising edge)
cfg_load  input  1  strobe: latch pat/pat_len/overlap and restart detection
pat  input  MAX_LEN  pattern; bit pat_len-1 is first-received, bit 0 last-received
pat_len  input  LEN_W  pattern length; 0 = disabled; >MAX_LEN clamps to MAX_LEN
overlap  input  1  1 = overlapping matches allowed, 0 = non-overlapping
en  input  1  data_in valid this cycle
data_in  input  1  serial bit
clr_cnt  input  1  synchronous clear of match_cnt
match  output  1  registered pulse, one cycle per detection
armed  output  1  high when state==ARMED
match_cnt  output  CNT_W  saturating detection count

Behaviour:
- Reset (reset==0 at edge): hist=0, fill=0, cfg_pat=0, cfg_len=0, cfg_ovl=0, state=IDLE, match=0, match_cnt=0, armed=0. Reset overrides every other input.
- Config: cfg_load=1 latches pat, clamped pat_len, overlap into cfg_* regs, sets hist=0, fill=0. A sample with en on the same cycle is discarded. Next state: FILL if len>0, else IDLE. Config inputs are ignored when cfg_load=0.
- History: on en=1 (no cfg_load), nh={hist[MAX_LEN-2:0],data_in}; hist<=nh. fill saturates at MAX_LEN, incrementing per accepted bit.
- Hit (combinational): en && !cfg_load && state!=IDLE && (fill+1 >= cfg_len) && nh[cfg_len-1:0]==cfg_pat[cfg_len-1:0].
- match<=hit, giving a latency of 1 cycle from the sampling edge. match=0 whenever en=0.
- Non-overlap mode: on hit, fill<=0 and hist<=0, so the next match needs cfg_len fresh bits. Overlap mode: fill continues.
- FSM states, held in the package enum:
  - IDLE: cfg_len==0. Stays until cfg_load with len>0.
  - FILL: fill<cfg_len. Moves to ARMED when fill reaches cfg_len-1 and an accepted bit arrives.
  - ARMED: a hit is possible on each en. In non-overlap mode, a hit returns the FSM to FILL (or stays ARMED if cfg_len==1). cfg_load returns to FILL or IDLE.
- armed is registered, equal to (state==ARMED).
- Counter: base = clr_cnt ? 0 : match_cnt. If hit and base != all-ones, add 1. clr_cnt and hit in the same cycle give match_cnt=1. The counter saturates at 2^CNT_W-1 with no wrap.
- en=0 cycles: no shifting and no state change. Gaps between valid bits are transparent.
- Reset low mid-stream: everything clears, including config, and the FSM is IDLE until the next cfg_load.
- Legacy equivalence: pat=1111, pat_len=4, overlap=1 reproduces the old detector. match is high on the 4th consecutive 1 and on every further 1, and a 0 drops the FSM back to FILL.

Decomposition:
- Package pattern_detector_pkg holds:
  - state_t enum {IDLE, FILL, ARMED}
  - default MAX_LEN/CNT_W constants
  - function len_clamp()
- Sub-module sat_counter (param W; ports clk, reset, clr, inc, q) implements match_cnt. Everything else stays in pattern_detector.

Test Plan:
- Legacy: cfg 1111/len4/ovl=1, stream 1,1,1,1,1,1,0,1 with en=1 -> match one cycle after bits 4,5,6 only; match_cnt=3; armed falls after the 0.
- Non-overlap: same pattern, ovl=0, eight 1s -> match after bits 4 and 8 only; match_cnt=2.
- Pattern 101, len3: stream 1,0,1,0,1 -> ovl=1 matches after bits 3 and 5; ovl=0 matches after bit 3 only.
- Gaps and config: pattern 0110 with en toggling 1,0,1,1,0,0,1 across the bits -> single match after the last valid bit. cfg_load with pat_len=0 -> IDLE, and no match on any stream. pat_len=12 with MAX_LEN=8 -> behaves as len 8.
- Counter (CNT_W=2): 5 hits -> match_cnt 1,2,3,3,3. clr_cnt coincident with a hit -> 1. clr_cnt alone -> 0.
- Reset: drop reset low for one cycle during FILL of 1111 after three 1s -> all outputs 0, state IDLE. A subsequent 1111 gives no match until a new cfg_load.
